// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one word load/store at a time with a fixed
// access latency, pipeline stall while busy, done pulse and request-error flag.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dataCacheReadEnable,
    input  logic        dataCacheWriteEnable,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        done,
    output logic        accessErr
);
    // state | meaning
    // IDLE  | waiting for a request; rejected requests flag accessErr here
    // BUSY  | access in flight, counter counts down the remaining cycles
    // DONE  | access complete, done pulses, pipeline released

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               op_wr;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic req, conflict, misaligned, out_of_range, legal, reject;
    logic accept, finish;

    assign req          = dataCacheReadEnable | dataCacheWriteEnable;
    assign conflict     = dataCacheReadEnable & dataCacheWriteEnable;
    assign misaligned   = |addr[1:0];
    // DEPTH_WORDS is a power of two, so any set bit above the index is out of range
    assign out_of_range = |addr[31:IDX_W+2];
    assign legal        = req & ~conflict & ~misaligned & ~out_of_range;
    assign reject       = req & ~legal;

    assign accept = (state == IDLE) && legal;
    assign finish = (state == BUSY) && (cnt == 4'd0);
    assign done   = (state == DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (legal) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'(LATENCY - 1);
                    stall     = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata_q   <= 32'd0;
            readData  <= 32'd0;
            accessErr <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            accessErr <= (state == IDLE) && reject;
            if (accept) begin
                op_wr   <= dataCacheWriteEnable;
                idx     <= addr[IDX_W+1:2];
                wdata_q <= writeData;
            end
            if (finish && !op_wr) begin
                readData <= mem[idx];
            end
        end
    end

    // A reset on the completing edge discards the pending store.
    always_ff @(posedge clk) begin
        if (!rst && finish && op_wr) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance driven from a
// vector table plus a reset corner case, and a LATENCY=1 instance address sweep.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        rd_en   [2];
    logic        wr_en   [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        stall_s [2];
    logic        done_s  [2];
    logic        err_s   [2];

    logic [31:0] last_rd [2];
    int          errors;
    int          checks;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
        .clk                 (clk),
        .rst                 (rst),
        .dataCacheReadEnable (rd_en[0]),
        .dataCacheWriteEnable(wr_en[0]),
        .addr                (addr_s[0]),
        .writeData           (wdata_s[0]),
        .readData            (rdata_s[0]),
        .stall               (stall_s[0]),
        .done                (done_s[0]),
        .accessErr           (err_s[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
        .clk                 (clk),
        .rst                 (rst),
        .dataCacheReadEnable (rd_en[1]),
        .dataCacheWriteEnable(wr_en[1]),
        .addr                (addr_s[1]),
        .writeData           (wdata_s[1]),
        .readData            (rdata_s[1]),
        .stall               (stall_s[1]),
        .done                (done_s[1]),
        .accessErr           (err_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One request on instance d; every cycle of the access is checked.
    task automatic acc(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input bit exp_err, input logic [31:0] exp_rd);
        int lat;
        lat = (d == 0) ? 2 : 1;
        @(negedge clk);
        rd_en[d] = rd; wr_en[d] = wr; addr_s[d] = a; wdata_s[d] = wd;
        #1;
        chk("stall_req", 32'(stall_s[d]), 32'(!exp_err));
        @(negedge clk);
        rd_en[d] = 1'b0; wr_en[d] = 1'b0; addr_s[d] = $urandom; wdata_s[d] = $urandom;
        if (exp_err) begin
            chk("err_pulse", 32'(err_s[d]), 32'd1);
            chk("err_stall", 32'(stall_s[d]), 32'd0);
            chk("err_done", 32'(done_s[d]), 32'd0);
            chk("err_rdata", rdata_s[d], last_rd[d]);
            @(negedge clk);
            chk("err_clear", 32'(err_s[d]), 32'd0);
        end else begin
            for (int k = 1; k <= lat; k++) begin
                chk("busy_stall", 32'(stall_s[d]), 32'd1);
                chk("busy_done", 32'(done_s[d]), 32'd0);
                @(negedge clk);
            end
            chk("done_pulse", 32'(done_s[d]), 32'd1);
            chk("done_stall", 32'(stall_s[d]), 32'd0);
            chk("done_err", 32'(err_s[d]), 32'd0);
            if (rd) last_rd[d] = exp_rd;
            chk("done_rdata", rdata_s[d], last_rd[d]);
        end
        addr_s[d] = 32'd0; wdata_s[d] = 32'd0;
    endtask

    initial begin
        logic [31:0] v;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rd_en[d] = 1'b0; wr_en[d] = 1'b0; addr_s[d] = 32'd0; wdata_s[d] = 32'd0;
            last_rd[d] = 32'd0;
        end

        tbl.push_back('{rd:0, wr:1, a:32'h10,       wd:32'hDEADBEEF, err:0, exp_rd:32'h0});
        tbl.push_back('{rd:1, wr:0, a:32'h10,       wd:32'h0,        err:0, exp_rd:32'hDEADBEEF});
        tbl.push_back('{rd:1, wr:0, a:32'h12,       wd:32'h0,        err:1, exp_rd:32'h0});
        tbl.push_back('{rd:0, wr:1, a:32'h20,       wd:32'h12345678, err:0, exp_rd:32'h0});
        tbl.push_back('{rd:1, wr:1, a:32'h20,       wd:32'h0BAD0BAD, err:1, exp_rd:32'h0});
        tbl.push_back('{rd:1, wr:0, a:32'h20,       wd:32'h0,        err:0, exp_rd:32'h12345678});
        tbl.push_back('{rd:0, wr:1, a:32'h0,        wd:32'hA5A5A5A5, err:0, exp_rd:32'h0});
        tbl.push_back('{rd:0, wr:1, a:32'h400,      wd:32'h0BADF00D, err:1, exp_rd:32'h0});
        tbl.push_back('{rd:1, wr:0, a:32'h0,        wd:32'h0,        err:0, exp_rd:32'hA5A5A5A5});
        tbl.push_back('{rd:0, wr:1, a:32'hFFFFFFFC, wd:32'h77777777, err:1, exp_rd:32'h0});
        tbl.push_back('{rd:0, wr:1, a:32'h41,       wd:32'h66666666, err:1, exp_rd:32'h0});
        tbl.push_back('{rd:0, wr:1, a:32'h40,       wd:32'h11112222, err:0, exp_rd:32'h0});
        tbl.push_back('{rd:1, wr:0, a:32'h40,       wd:32'h0,        err:0, exp_rd:32'h11112222});
        tbl.push_back('{rd:1, wr:0, a:32'h0,        wd:32'h0,        err:0, exp_rd:32'hA5A5A5A5});

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdata", rdata_s[d], 32'd0);
            chk("rst_stall", 32'(stall_s[d]), 32'd0);
            chk("rst_done", 32'(done_s[d]), 32'd0);
            chk("rst_err", 32'(err_s[d]), 32'd0);
        end
        rst = 1'b0;

        foreach (tbl[i]) begin
            acc(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].err, tbl[i].exp_rd);
        end

        // Store to 0x40 interrupted by reset in its second BUSY cycle.
        @(negedge clk);
        wr_en[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = 32'h99998888;
        #1;
        chk("rstmid_stall_req", 32'(stall_s[0]), 32'd1);
        @(negedge clk);
        wr_en[0] = 1'b0;
        chk("rstmid_busy1", 32'(stall_s[0]), 32'd1);
        @(negedge clk);
        chk("rstmid_busy2", 32'(stall_s[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_rdata", rdata_s[0], 32'd0);
        chk("rstmid_stall", 32'(stall_s[0]), 32'd0);
        chk("rstmid_done", 32'(done_s[0]), 32'd0);
        chk("rstmid_err", 32'(err_s[0]), 32'd0);
        rst = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        acc(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h11112222);

        // A request arriving during DONE is ignored: no error, no new access.
        acc(0, 1'b0, 1'b1, 32'h44, 32'h01020304, 1'b0, 32'h0);
        rd_en[0] = 1'b1; wr_en[0] = 1'b1; addr_s[0] = 32'h3;
        @(negedge clk);
        rd_en[0] = 1'b0; wr_en[0] = 1'b0; addr_s[0] = 32'h0;
        chk("done_req_err", 32'(err_s[0]), 32'd0);
        chk("done_req_stall", 32'(stall_s[0]), 32'd0);

        // LATENCY=1 sweep over every word, then top-of-range rejection.
        for (int i = 0; i < 256; i++) begin
            v = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
            acc(1, 1'b0, 1'b1, 32'(i) << 2, v, 1'b0, 32'h0);
            acc(1, 1'b1, 1'b0, 32'(i) << 2, 32'h0, 1'b0, v);
        end
        acc(1, 1'b0, 1'b1, 32'h400, 32'hCAFECAFE, 1'b1, 32'h0);
        acc(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h5A5A0000);
        acc(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'd255 * 32'h9E3779B1 ^ 32'h5A5A0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
